nco_sweep_ctrl: RTL
===================

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL provide parameter FTW_W, default 32, frequency tuning word width.
REQ-002 SHALL provide parameter DWELL_W, default 16, dwell counter width.
REQ-003 SHALL have port clk_top  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_top  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle sweep request.
REQ-006 SHALL have port abort  input  1  sweep cancel, level-sampled.
REQ-007 SHALL have port cfg_start_ftw  input  FTW_W  first tuning word.
REQ-008 SHALL have port cfg_step_ftw  input  FTW_W  unsigned increment per step.
REQ-009 SHALL have port cfg_stop_ftw  input  FTW_W  final tuning word.
REQ-010 SHALL have port cfg_dwell  input  DWELL_W  clocks per tuning word; 0 treated as 1.
REQ-011 SHALL have port cfg_loop  input  1  restart sweep automatically after completion.
REQ-012 SHALL have port nco_ftw  output  FTW_W  tuning word to NCO_in.
REQ-013 SHALL have port nco_enable  output  1  drives NCO_enable.
REQ-014 SHALL have port busy  output  1  high in SWEEP or LAST.
REQ-015 SHALL have port step_strobe  output  1  high the cycle nco_ftw takes a new value.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, SWEEP, LAST, DONE.
REQ-018 SHALL, in IDLE on start=1, latch all cfg_* inputs, and drive nco_ftw=cfg_start_ftw with nco_enable=1 in the next cycle (latency 1).
REQ-019 SHALL ignore start while busy or in DONE; cfg_* changes during a sweep have no effect.
REQ-020 SHALL hold each tuning word for exactly max(cfg_dwell,1) cycles via a down-counter.
REQ-021 SHALL, at dwell expiry in SWEEP, compute next = nco_ftw + step with carry; if carry=1 or next >= stop, load stop and enter LAST; otherwise load next and remain in SWEEP.
REQ-022 SHALL enter LAST directly from IDLE when latched stop <= start or step == 0.
REQ-023 SHALL, at dwell expiry in LAST, enter DONE, with nco_enable=0 and done=1 for exactly one cycle.
REQ-024 SHALL leave DONE for IDLE, or restart as from IDLE with the latched config when cfg_loop is latched 1; in the restart case done and the first word coincide with no gap cycle.
REQ-025 SHALL, on abort=1 in any state, enter IDLE next cycle with nco_enable=0, done=0 and nco_ftw held; abort has priority over start and dwell expiry.
REQ-026 SHALL keep nco_ftw unchanged in IDLE and DONE.
REQ-027 SHALL assert step_strobe together with the first word and every subsequent load, including the load of stop.

Reset
REQ-028 SHALL, while rst_top=0, force state=IDLE, nco_ftw=0, nco_enable=0, busy=0, step_strobe=0, done=0, dwell counter=0 and latched config=0, independent of clk_top.
REQ-029 SHALL resume from IDLE on the first clock after reset release; reset mid-sweep discards the sweep.

Configuration
REQ-030 SHALL, with macro NCO_SWEEP_BIDIR_EN defined, add state DOWN: LAST expiry enters DOWN, which subtracts step with borrow and terminates at start (borrow or next <= start loads start, then DONE after its dwell).
REQ-031 SHALL, without NCO_SWEEP_BIDIR_EN, omit DOWN and the subtractor entirely; the sweep is up-only.

Structure
REQ-032 SHALL place the state encoding typedef and the FTW_W/DWELL_W defaults in shared package nco_pkg.
REQ-033 SHALL isolate the dwell down-counter in sub-module nco_dwell_cnt (load, expiry flag); everything else stays in one module.

Verification
REQ-034 SHALL cover: start=1000, step=500, stop=2500, dwell=4 -> nco_ftw 1000,1500,2000,2500 for 4 cycles each; enable cycles 1-16; done at cycle 17.
REQ-035 SHALL cover: start=0xFFFFFF00, step=0x200, stop=0xFFFFFFFF -> carry detected, second word 0xFFFFFFFF, then done.
REQ-036 SHALL cover: step=0, or stop=100 with start=200 -> single dwell at start word, then done.
REQ-037 SHALL cover: abort at cycle 6 of the REQ-034 sweep -> IDLE at cycle 7 with nco_enable=0, nco_ftw=1500 held, no done.
REQ-038 SHALL cover: cfg_loop=1 with REQ-034 values -> after 2500 the word returns to 1000 in the cycle after the last 2500 cycle, with done pulsed in that same cycle.
REQ-039 SHALL cover: rst_top=0 asynchronously mid-sweep -> all outputs 0 without waiting for a clock edge; start after release begins a fresh sweep.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared types and width defaults for the NCO sweep controller.
// ST_DOWN exists only when NCO_SWEEP_BIDIR_EN is defined.
package nco_pkg;

  localparam int NCO_FTW_W   = 32;
  localparam int NCO_DWELL_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SWEEP = 3'd1,
    ST_LAST  = 3'd2,
`ifdef NCO_SWEEP_BIDIR_EN
    ST_DONE  = 3'd3,
    ST_DOWN  = 3'd4
`else
    ST_DONE  = 3'd3
`endif
  } nco_state_t;

endpackage

// File: rtl/nco_dwell_cnt.sv
// Dwell down-counter: load sets the count, expired flags zero (same-cycle, combinational).
// Latency: load visible next cycle; no backpressure.
module nco_dwell_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear FTW sweep controller for an NCO; first word 1 cycle after start, no backpressure.
// NCO_SWEEP_BIDIR_EN adds a downward leg (ST_DOWN) back to the start word after the stop word.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int FTW_W   = NCO_FTW_W,
  parameter int DWELL_W = NCO_DWELL_W
) (
  input  logic               clk_top,
  input  logic               rst_top,
  input  logic               start,
  input  logic               abort,
  input  logic [FTW_W-1:0]   cfg_start_ftw,
  input  logic [FTW_W-1:0]   cfg_step_ftw,
  input  logic [FTW_W-1:0]   cfg_stop_ftw,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  output logic [FTW_W-1:0]   nco_ftw,
  output logic               nco_enable,
  output logic               busy,
  output logic               step_strobe,
  output logic               done
);

  nco_state_t         state;
  logic [FTW_W-1:0]   start_q;
  logic [FTW_W-1:0]   step_q;
  logic [FTW_W-1:0]   stop_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               loop_q;

  logic               expired;
  logic               cnt_load;
  logic [DWELL_W-1:0] cnt_val;
  logic [DWELL_W-1:0] dw_in_m1;
  logic [DWELL_W-1:0] dw_q_m1;
  logic               run_st;
  logic               fin;
  logic               single_in;
  logic               single_q;
  logic [FTW_W:0]     up_sum;
  logic               up_hit;

  // A dwell of 0 behaves as 1, so the reload value saturates at zero.
  assign dw_in_m1 = (cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1;
  assign dw_q_m1  = (dwell_q == '0) ? '0 : dwell_q - 1'b1;

  assign single_in = (cfg_stop_ftw <= cfg_start_ftw) || (cfg_step_ftw == '0);
  assign single_q  = (stop_q <= start_q) || (step_q == '0);

  assign up_sum = {1'b0, nco_ftw} + {1'b0, step_q};
  assign up_hit = up_sum[FTW_W] || (up_sum[FTW_W-1:0] >= stop_q);

`ifdef NCO_SWEEP_BIDIR_EN
  logic           down_fin;
  logic [FTW_W:0] dn_dif;
  logic           dn_hit;

  assign dn_dif = {1'b0, nco_ftw} - {1'b0, step_q};
  assign dn_hit = dn_dif[FTW_W] || (dn_dif[FTW_W-1:0] <= start_q);
  assign run_st = (state == ST_SWEEP) || (state == ST_LAST) || (state == ST_DOWN);
  assign fin    = expired && (state == ST_DOWN) && down_fin;
`else
  assign run_st = (state == ST_SWEEP) || (state == ST_LAST);
  assign fin    = expired && (state == ST_LAST);
`endif

  // Reload on every word change, including the looped restart.
  assign cnt_load = !abort &&
                    (((state == ST_IDLE) && start) ||
                     (run_st && expired && !(fin && !loop_q)));
  assign cnt_val  = (state == ST_IDLE) ? dw_in_m1 : dw_q_m1;

  nco_dwell_cnt #(
    .W(DWELL_W)
  ) u_dwell (
    .clk      (clk_top),
    .rst_n    (rst_top),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expired  (expired)
  );

  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      state       <= ST_IDLE;
      nco_ftw     <= '0;
      nco_enable  <= 1'b0;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      start_q     <= '0;
      step_q      <= '0;
      stop_q      <= '0;
      dwell_q     <= '0;
      loop_q      <= 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
      down_fin    <= 1'b0;
`endif
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        nco_enable <= 1'b0;
        busy       <= 1'b0;
      end else if (fin) begin
        done <= 1'b1;
        if (loop_q) begin
          // Restart overlaps the done pulse: no idle gap between sweeps.
          nco_ftw     <= start_q;
          step_strobe <= 1'b1;
          state       <= single_q ? ST_LAST : ST_SWEEP;
`ifdef NCO_SWEEP_BIDIR_EN
          down_fin    <= 1'b0;
`endif
        end else begin
          state      <= ST_DONE;
          nco_enable <= 1'b0;
          busy       <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              start_q     <= cfg_start_ftw;
              step_q      <= cfg_step_ftw;
              stop_q      <= cfg_stop_ftw;
              dwell_q     <= cfg_dwell;
              loop_q      <= cfg_loop;
              nco_ftw     <= cfg_start_ftw;
              nco_enable  <= 1'b1;
              busy        <= 1'b1;
              step_strobe <= 1'b1;
              state       <= single_in ? ST_LAST : ST_SWEEP;
            end
          end
          ST_SWEEP: begin
            if (expired) begin
              step_strobe <= 1'b1;
              if (up_hit) begin
                nco_ftw <= stop_q;
                state   <= ST_LAST;
              end else begin
                nco_ftw <= up_sum[FTW_W-1:0];
              end
            end
          end
`ifdef NCO_SWEEP_BIDIR_EN
          ST_LAST: begin
            if (expired) begin
              step_strobe <= 1'b1;
              state       <= ST_DOWN;
              down_fin    <= dn_hit;
              nco_ftw     <= dn_hit ? start_q : dn_dif[FTW_W-1:0];
            end
          end
          ST_DOWN: begin
            if (expired) begin
              step_strobe <= 1'b1;
              down_fin    <= dn_hit;
              nco_ftw     <= dn_hit ? start_q : dn_dif[FTW_W-1:0];
            end
          end
`else
          ST_LAST: begin
          end
`endif
          ST_DONE: state <= ST_IDLE;
          default: begin
            state      <= ST_IDLE;
            nco_enable <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
